// File: rtl/tiny_host_pkg.sv
// Shared constants, FSM state type and sizing helper for the tiny host controller.
package tiny_host_pkg;

  localparam logic [5:0] AddrXp      = 6'd3;
  localparam logic [5:0] AddrYp      = 6'd5;
  localparam logic [5:0] AddrXq      = 6'd6;
  localparam logic [5:0] AddrYq      = 6'd7;
  localparam logic [5:0] AddrRes0    = 6'd9;
  localparam logic [5:0] AddrResLast = 6'd14;
  localparam int unsigned NumRes     = 6;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StRun,
    StRead,
    StDrain
  } state_e;

  // Stream words needed to carry one tiny bus element.
  function automatic int unsigned nw(int unsigned d_width, int unsigned word_w);
    return (d_width + word_w - 1) / word_w;
  endfunction

  function automatic logic [5:0] op_addr(logic [1:0] idx);
    case (idx)
      2'd0:    return AddrXp;
      2'd1:    return AddrYp;
      2'd2:    return AddrXq;
      default: return AddrYq;
    endcase
  endfunction

endpackage

// File: rtl/tiny_host_ser.sv
// Word-wide shift register: assembles NW stream words into one element (LSW first)
// or serializes a parallel-loaded element back out as NW words.
module tiny_host_ser
  import tiny_host_pkg::*;
#(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned D_WIDTH = 1188,
  parameter int unsigned NW      = nw(D_WIDTH, WORD_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [D_WIDTH-1:0] ld_data,
  input  logic               shift,
  input  logic [WORD_W-1:0]  sin,
  output logic [D_WIDTH-1:0] par,
  output logic [WORD_W-1:0]  word
);
  localparam int unsigned RegW = NW * WORD_W;

  logic [RegW-1:0] sr_q;
  logic            unused_sr;

  // New words enter at the top so the first word ends up least significant.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= RegW'(ld_data);
    end else if (shift) begin
      sr_q <= RegW'({sin, sr_q} >> WORD_W);
    end
  end

  assign par       = sr_q[D_WIDTH-1:0];
  assign word      = sr_q[WORD_W-1:0];
  assign unused_sr = ^sr_q;

endmodule

// File: rtl/tiny_host_ctrl.sv
// Host-side controller for the tiny core: load four operands, run, read back six results.
// Build option: define TINY_HOST_TIMEOUT_EN to bound the RUN wait and flag err on expiry.
module tiny_host_ctrl
  import tiny_host_pkg::*;
#(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned D_WIDTH = 1188,
  parameter int unsigned TIMEOUT = 2**24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               t_reset,
  output logic               t_sel,
  output logic [5:0]         t_addr,
  output logic               t_w,
  output logic [D_WIDTH-1:0] t_data,
  input  logic [D_WIDTH-1:0] t_out,
  input  logic               t_done,
  output logic               busy,
  output logic               err
);
  localparam int unsigned NW  = nw(D_WIDTH, WORD_W);
  localparam int unsigned WcW = $clog2(NW + 1);
  localparam int unsigned OcW = $clog2(NumRes * NW + 1);
  localparam logic [WcW-1:0] WordLast = WcW'(NW - 1);
  localparam logic [OcW-1:0] OutLast  = OcW'(NumRes * NW - 1);

  state_e         state_q;
  logic [WcW-1:0] word_q;
  logic [1:0]     op_q;
  logic           rd_phase_q;
  logic [OcW-1:0] out_cnt_q;
  logic           done_q;

  logic in_fire, out_fire, capture, done_edge, tmo_hit;
  logic [WORD_W-1:0]  unused_ld_word;
  logic [D_WIDTH-1:0] unused_dr_par;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign capture   = (state_q == StRead) & rd_phase_q;
  assign done_edge = t_done & ~done_q;

  tiny_host_ser #(
    .WORD_W (WORD_W),
    .D_WIDTH(D_WIDTH),
    .NW     (NW)
  ) u_ld_ser (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b0),
    .ld_data('0),
    .shift  (in_fire),
    .sin    (in_data),
    .par    (t_data),
    .word   (unused_ld_word)
  );

  tiny_host_ser #(
    .WORD_W (WORD_W),
    .D_WIDTH(D_WIDTH),
    .NW     (NW)
  ) u_dr_ser (
    .clk    (clk),
    .reset  (reset),
    .load   (capture),
    .ld_data(t_out),
    .shift  (out_fire),
    .sin    ('0),
    .par    (unused_dr_par),
    .word   (out_data)
  );

`ifdef TINY_HOST_TIMEOUT_EN
  localparam int unsigned TmW = $clog2(TIMEOUT + 1);
  logic [TmW-1:0] tmo_q;
  logic           err_q;

  assign tmo_hit = (tmo_q == TmW'(TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != StRun) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TmW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == StRun && tmo_hit && !done_edge) begin
      err_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      t_reset    <= 1'b1;
      t_sel      <= 1'b0;
      t_w        <= 1'b0;
      t_addr     <= '0;
      busy       <= 1'b0;
      word_q     <= '0;
      op_q       <= '0;
      rd_phase_q <= 1'b0;
      out_cnt_q  <= '0;
      done_q     <= 1'b1;
    end else begin
      // Outside RUN the history reads as high, so a level already present on entry is no edge.
      done_q <= (state_q == StRun) ? t_done : 1'b1;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q   <= StLoad;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            word_q    <= '0;
            op_q      <= '0;
            out_cnt_q <= '0;
          end
        end
        StLoad: begin
          if (in_fire) begin
            if (word_q == WordLast) begin
              word_q   <= '0;
              in_ready <= 1'b0;
              t_sel    <= 1'b1;
              t_w      <= 1'b1;
              t_addr   <= op_addr(op_q);
              state_q  <= StWrite;
            end else begin
              word_q <= word_q + WcW'(1);
            end
          end
        end
        StWrite: begin
          t_sel <= 1'b0;
          t_w   <= 1'b0;
          if (op_q == 2'd3) begin
            t_reset <= 1'b0;
            t_addr  <= '0;
            state_q <= StRun;
          end else begin
            op_q     <= op_q + 2'd1;
            in_ready <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StRun: begin
          if (done_edge) begin
            t_sel      <= 1'b1;
            t_addr     <= AddrRes0;
            rd_phase_q <= 1'b0;
            state_q    <= StRead;
          end else if (tmo_hit) begin
            t_reset <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRead: begin
          // Address is held for two cycles; t_out is valid in the second.
          if (!rd_phase_q) begin
            rd_phase_q <= 1'b1;
          end else begin
            rd_phase_q <= 1'b0;
            t_sel      <= 1'b0;
            out_valid  <= 1'b1;
            out_last   <= (out_cnt_q == OutLast);
            word_q     <= '0;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          if (out_fire) begin
            out_cnt_q <= out_cnt_q + OcW'(1);
            if (word_q == WordLast) begin
              word_q    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (t_addr == AddrResLast) begin
                t_reset <= 1'b1;
                t_addr  <= '0;
                busy    <= 1'b0;
                state_q <= StIdle;
              end else begin
                t_addr  <= t_addr + 6'd1;
                t_sel   <= 1'b1;
                state_q <= StRead;
              end
            end else begin
              word_q   <= word_q + WcW'(1);
              out_last <= (out_cnt_q + OcW'(1) == OutLast);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_host_ctrl.sv
// Randomized self-checking bench for tiny_host_ctrl with a behavioural tiny-core model.
module tb_tiny_host_ctrl;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned D_WIDTH = 1188;
  localparam int unsigned NW      = (D_WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned NOUT    = 6 * NW;
  localparam int unsigned NCHUNK  = (D_WIDTH + 63) / 64;
  localparam int unsigned TMO     = 1000;

  typedef logic [D_WIDTH-1:0] elem_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [WORD_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               t_reset, t_sel, t_w, t_done;
  logic [5:0]         t_addr;
  elem_t              t_data, t_out;
  logic               busy, err;

  always #5 clk = ~clk;

  tiny_host_ctrl #(
    .WORD_W (WORD_W),
    .D_WIDTH(D_WIDTH),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .t_reset  (t_reset),
    .t_sel    (t_sel),
    .t_addr   (t_addr),
    .t_w      (t_w),
    .t_data   (t_data),
    .t_out    (t_out),
    .t_done   (t_done),
    .busy     (busy),
    .err      (err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus and reference data for one transaction.
  logic [WORD_W-1:0] in_words [4*NW];
  elem_t             res_mem [9:14];
  logic [5:0]        op_addrs [4] = '{6'd3, 6'd5, 6'd6, 6'd7};
  int                done_mode;  // 0: rise 500 after start, 1: high on entry then re-rise, 2: never
  int unsigned       run_cnt;

  // Observations.
  logic [5:0]        wr_addr_q [$];
  elem_t             wr_data_q [$];
  logic [WORD_W-1:0] out_q [$];
  logic              last_q [$];
  int unsigned       run_cycles;
  bit                prev_stall;
  logic [WORD_W-1:0] prev_data;

  // Tiny core: registered read port, done generator keyed off its reset.
  always @(posedge clk) begin
    if (t_sel && !t_w && t_addr >= 6'd9 && t_addr <= 6'd14) t_out <= res_mem[t_addr];
    else t_out <= '1;
    if (t_reset) begin
      run_cnt <= 0;
      t_done  <= (done_mode == 1);
    end else begin
      run_cnt <= run_cnt + 1;
      case (done_mode)
        0: if (run_cnt == 499) t_done <= 1'b1;
        1: if (run_cnt == 99) t_done <= 1'b0; else if (run_cnt == 299) t_done <= 1'b1;
        default: t_done <= 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (t_w) begin
        wr_addr_q.push_back(t_addr);
        wr_data_q.push_back(t_data);
        check_eq("write_sel_treset", {t_sel, t_reset}, 2'b11);
      end
      if (t_sel && !t_w) check_eq("read_treset", t_reset, 0);
      if (busy && !t_reset && !t_sel && !out_valid) run_cycles++;
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
    end
  end

  function automatic elem_t rand_elem();
    logic [NW*WORD_W-1:0] cat;
    for (int w = 0; w < NW; w++) cat[w*WORD_W +: WORD_W] = $urandom();
    return cat[D_WIDTH-1:0];
  endfunction

  function automatic elem_t exp_elem(int unsigned k);
    logic [NW*WORD_W-1:0] cat;
    for (int w = 0; w < NW; w++) cat[w*WORD_W +: WORD_W] = in_words[k*NW + w];
    return cat[D_WIDTH-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(int unsigned j);
    logic [NW*WORD_W-1:0] cat;
    cat = '0;
    cat[D_WIDTH-1:0] = res_mem[9 + j / NW];
    return cat[(j % NW)*WORD_W +: WORD_W];
  endfunction

  task automatic new_txn(input int mode);
    done_mode = mode;
    foreach (in_words[i]) in_words[i] = $urandom();
    for (int a = 9; a <= 14; a++) res_mem[a] = rand_elem();
    wr_addr_q.delete();
    wr_data_q.delete();
    out_q.delete();
    last_q.delete();
    run_cycles = 0;
  endtask

  // Offer words in order; returns just after the n-th word has been accepted.
  task automatic send_words(input int unsigned n, input bit gapped);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    bit acc = 1'b0;
    while (cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (acc) idx++;
      if (idx == n) break;
      in_valid = gapped ? (cyc % 3 != 0) : ($urandom_range(3) != 0);
      in_data  = in_valid ? in_words[idx] : $urandom();
      acc      = in_valid && in_ready;
    end
    in_valid = 1'b0;
    check_eq("words_accepted", idx, n);
  endtask

  task automatic wait_idle(input bit do_stall);
    int unsigned cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    while (cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (do_stall && !stalled && out_q.size() >= 100) begin
        out_ready  = 1'b0;
        stalled    = 1'b1;
        stall_left = 9;
      end else begin
        out_ready = ($urandom_range(3) != 0);
      end
      @(negedge clk);
      if (!busy) break;
    end
    out_ready = 1'b0;
    check_eq("idle_reached", busy, 0);
  endtask

  task automatic check_txn(input int unsigned exp_run);
    elem_t exp;
    check_eq("n_writes", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check_eq("write_addr", wr_addr_q[i], op_addrs[i]);
      exp = exp_elem(i);
      for (int c = 0; c < NCHUNK; c++)
        check_eq("write_data", 64'(wr_data_q[i] >> (64*c)), 64'(exp >> (64*c)));
    end
    check_eq("run_cycles", run_cycles, exp_run);
    check_eq("n_out_words", out_q.size(), NOUT);
    for (int j = 0; j < NOUT && j < out_q.size(); j++) begin
      check_eq("out_data", out_q[j], exp_word(j));
      check_eq("out_last", last_q[j], (j == NOUT - 1));
    end
    check_eq("end_treset", t_reset, 1);
    check_eq("end_in_ready", in_ready, 0);
    check_eq("end_err", err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    new_txn(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_t_reset", t_reset, 1);
    check_eq("rst_t_sel", t_sel, 0);
    check_eq("rst_t_w", t_w, 0);
    check_eq("rst_t_addr", t_addr, 0);
    check_eq("rst_t_data", |t_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // Gapped load, random drain with a 10-cycle stall mid-stream.
    new_txn(0);
    send_words(4 * NW, 1'b1);
    wait_idle(1'b1);
    check_txn(501);

    // Reset part-way through the second operand.
    new_txn(0);
    send_words(50, 1'b1);
    reset = 1'b1;
    check_eq("pre_reset_writes", wr_addr_q.size(), 50 / NW);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_t_reset", t_reset, 1);
    repeat (5) @(negedge clk);
    check_eq("mid_rst_no_write", wr_addr_q.size(), 0);
    new_txn(0);
    send_words(4 * NW, 1'b0);
    wait_idle(1'b0);
    check_txn(501);

    // t_done already high on RUN entry: only the later re-rise may start READ.
    new_txn(1);
    send_words(4 * NW, 1'b0);
    wait_idle(1'b1);
    check_txn(301);

`ifdef TINY_HOST_TIMEOUT_EN
    begin
      int unsigned cyc = 0;
      new_txn(2);
      send_words(4 * NW, 1'b1);
      out_ready = 1'b1;
      while (cyc < 4000 && !err) begin
        @(negedge clk);
        cyc++;
      end
      check_eq("tmo_err", err, 1);
      check_eq("tmo_run_cycles", run_cycles, TMO);
      check_eq("tmo_no_out", out_q.size(), 0);
      check_eq("tmo_busy", busy, 0);
      check_eq("tmo_t_reset", t_reset, 1);
      out_ready = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_host_ctrl.md
TINY_HOST_CTRL -- requirements
Module: tiny_host_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32, stream word width in bits.
REQ-002 SHALL have parameter D_WIDTH, default 1188, width of one tiny bus element (WIDTH_D0+1).
REQ-003 SHALL have parameter TIMEOUT, default 2**24, maximum cycles waited for done (used only with the configuration macro).
REQ-004 SHALL have port clk, input, 1, single clock; one clock, reset synchronous active-high.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports in_data (input, WORD_W), in_valid (input, 1) and in_ready (output, 1), forming the operand stream.
REQ-007 SHALL have ports out_data (output, WORD_W), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1), forming the result stream.
REQ-008 SHALL have tiny-side outputs t_reset (1), t_sel (1), t_addr (6), t_w (1) and t_data (D_WIDTH).
REQ-009 SHALL have tiny-side inputs t_out (D_WIDTH) and t_done (1).
REQ-010 SHALL have outputs busy (1) and err (1).

Function
REQ-011 SHALL define NW = ceil(D_WIDTH/WORD_W) (38 at defaults) words per element, word 0 = least-significant bits.
REQ-012 SHALL accept input words only on in_valid && in_ready; in_ready high only in LOAD.
REQ-013 SHALL assemble 4 operands of NW words each, written in order to tiny addresses 3, 5, 6, 7 (xp, yp, xq, yq).
REQ-014 SHALL ignore the in_data bits above D_WIDTH in the last word of each operand.
REQ-015 SHALL issue each write as one cycle with t_sel=1, t_w=1, t_addr and t_data stable, t_reset=1.
REQ-016 SHALL use FSM states IDLE, LOAD, WRITE, RUN, READ, DRAIN.
REQ-017 SHALL leave IDLE for LOAD on the first in_valid.
REQ-018 SHALL move LOAD to WRITE after word NW, then back to LOAD, or to RUN after the fourth write.
REQ-019 SHALL deassert t_reset and hold t_sel=0, t_w=0 in RUN.
REQ-020 SHALL leave RUN on a rising edge of t_done (t_done high now, low in the previous RUN cycle); t_done already high on RUN entry SHALL NOT count.
REQ-021 SHALL read addresses 9..14 in ascending order in READ: t_sel=1, t_w=0, t_addr driven, t_out captured exactly one cycle later.
REQ-022 SHALL stream each captured element in DRAIN as NW words, LSW first, with unused upper bits of the last word zero.
REQ-023 SHALL hold out_data stable while out_valid && !out_ready.
REQ-024 SHALL assert out_last only on word 6*NW-1 (227 at defaults) and return to IDLE after it is accepted.
REQ-025 SHALL keep t_reset=0 through READ/DRAIN and restore t_reset=1 in IDLE.
REQ-026 SHALL hold busy high in every state except IDLE.

Reset
REQ-027 SHALL on reset enter IDLE with t_reset=1, t_sel=0, t_w=0, t_addr=0, t_data=0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, err=0, and all counters cleared.
REQ-028 SHALL, when reset is asserted in any state, abandon the partial operand or result with no further t_w pulse or output word.

Configuration
REQ-029 SHALL, with TINY_HOST_TIMEOUT_EN defined, count RUN cycles; on reaching TIMEOUT without a done edge, set err=1 (sticky until reset) and return to IDLE with no result words.
REQ-030 SHALL, without TINY_HOST_TIMEOUT_EN, wait indefinitely in RUN with err tied to 0.

Structure
REQ-031 SHALL take tiny address constants (3,5,6,7,9..14), state enum type and the NW function from a shared package tiny_host_pkg.
REQ-032 SHALL contain one sub-module, tiny_host_ser, the NW-word-to-D_WIDTH shift assembler/serializer, instanced once for load and once for drain.

Verification
REQ-033 Reset check: after reset all outputs at REQ-027 values, t_reset=1.
REQ-034 Operand load: 152 words with in_valid gapped every third cycle, element k words = k+1 -> exactly 4 t_w pulses at addrs 3,5,6,7 with t_data = replicated pattern, bits above 1187 clear.
REQ-035 Full run: bench model raises t_done 500 cycles after t_reset falls, returns t_out = addr -> reads 9..14, 228 out words, out_last on word 227 only, busy then falls.
REQ-036 Backpressure: out_ready low 10 cycles mid-DRAIN -> out_data/out_valid unchanged; no word lost or duplicated.
REQ-037 Reset mid-LOAD after word 50 -> IDLE next cycle, no t_w, subsequent full load succeeds.
REQ-038 With TINY_HOST_TIMEOUT_EN, TIMEOUT=1000, t_done never raised -> err=1 exactly 1000 cycles after RUN entry, no out_valid.
